// File: rtl/seconds_display.sv
// Converts the 6-bit elapsed-seconds count to two BCD digits with a subtract-by-10 FSM
// and drives a 2-digit multiplexed 7-segment display from those digits.
module seconds_display #(
  parameter int REFRESH_DIV     = 25_000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       valid
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [0:0]       state;
  logic             pending;
  logic [5:0]       last;
  logic [5:0]       work;
  logic [2:0]       tens;
  logic [CNT_W-1:0] refresh_cnt;
  logic             digit_sel;
  logic [6:0]       seg_next;

  // Active-high segment pattern {g,f,e,d,c,b,a}; out-of-range digits stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Converter control: outputs publish only on the completing edge, so they never show partial values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pending  <= 1'b1;
      last     <= 6'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending || (seconds != last)) begin
            last    <= seconds;
            pending <= 1'b0;
            state   <= ST_CONVERT;
          end
        end
        default: begin
          if (work < 6'd10) begin
            bcd_tens <= {1'b0, tens};
            bcd_ones <= work[3:0];
            valid    <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Converter datapath: reloaded every idle cycle, only the load on the start edge matters.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      work <= seconds;
      tens <= 3'd0;
    end else if (work >= 6'd10) begin
      work <= work - 6'd10;
      tens <= tens + 3'd1;
    end
  end

  always_comb begin
    seg_next = 7'h00;
    if (!blank && valid && !(digit_sel && LEAD_ZERO_BLANK && (bcd_tens == 4'd0)))
      seg_next = seg_decode(digit_sel ? bcd_tens : bcd_ones);
    if (SEG_ACTIVE_LOW)
      seg_next = ~seg_next;
  end

  // Display mux: outputs are registered and so lag digit_sel/bcd/blank by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      seg         <= SEG_OFF;
      digit_en    <= 2'b01;
    end else begin
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        digit_sel   <= ~digit_sel;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
      digit_en <= digit_sel ? 2'b10 : 2'b01;
      seg      <= seg_next;
    end
  end

endmodule

// File: tb/tb_seconds_display.sv
// Randomized bench for seconds_display: a transaction-level model predicts each conversion
// result and completion edge plus the expected display outputs; a monitor checks them.
module tb_seconds_display;

  localparam int RDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] seconds = 6'd0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       valid;

  seconds_display #(
    .REFRESH_DIV(RDIV),
    .SEG_ACTIVE_LOW(1'b1),
    .LEAD_ZERO_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seconds(seconds),
    .blank(blank),
    .seg(seg),
    .digit_en(digit_en),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones),
    .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     t;
    int     o;
    longint e;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  longint edge_n = 0;

  // model state
  bit         m_pending;
  int         m_last;
  longint     m_idle_edge;
  bit         m_conv_active;
  int         m_conv_t, m_conv_o;
  longint     m_conv_edge;
  bit         m_disp_v;
  int         m_disp_t, m_disp_o;
  int         m_cnt;
  bit         m_dsel;
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_en = 2'b01;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_model(input bit dsel, input int t, input int o,
                                           input bit v, input logic blk);
    bit on;
    on = !blk && v && !(dsel && t == 0);
    return on ? ~enc(dsel ? t : o) : 7'h7F;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model, evaluated at every rising edge from the inputs alone.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        q.delete();
        m_pending = 1; m_last = 0; m_idle_edge = 0; m_conv_active = 0;
        m_disp_v = 0; m_disp_t = 0; m_disp_o = 0;
        m_cnt = 0; m_dsel = 0;
        exp_seg = 7'h7F; exp_en = 2'b01;
      end else begin
        exp_seg = seg_model(m_dsel, m_disp_t, m_disp_o, m_disp_v, blank);
        exp_en  = m_dsel ? 2'b10 : 2'b01;
        if (m_cnt == RDIV - 1) begin
          m_cnt = 0;
          m_dsel = !m_dsel;
        end else begin
          m_cnt++;
        end
        if (m_conv_active && edge_n == m_conv_edge) begin
          m_disp_t = m_conv_t; m_disp_o = m_conv_o; m_disp_v = 1; m_conv_active = 0;
        end
        if (edge_n >= m_idle_edge && (m_pending || int'(seconds) != m_last)) begin
          m_conv_t      = int'(seconds) / 10;
          m_conv_o      = int'(seconds) % 10;
          m_conv_edge   = edge_n + m_conv_t + 1;
          m_idle_edge   = m_conv_edge + 1;
          m_conv_active = 1;
          m_last        = int'(seconds);
          m_pending     = 0;
          q.push_back('{t: m_conv_t, o: m_conv_o, e: m_conv_edge});
        end
      end
    end
  end

  // Monitor: samples on the falling edge; a conversion result is presented when valid rises or the digits change.
  initial begin
    bit   pv = 0;
    logic [3:0] pt = 0, po = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_valid", valid, 0);
        chk("reset_bcd", {bcd_tens, bcd_ones}, 0);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_digit_en", digit_en, 2'b01);
        pv = 0; pt = 0; po = 0;
      end else begin
        chk("seg", seg, exp_seg);
        chk("digit_en", digit_en, exp_en);
        if ((valid && !pv) || bcd_tens != pt || bcd_ones != po) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update actual=%0d/%0d required=no change (edge %0d)",
                     bcd_tens, bcd_ones, edge_n);
          end else begin
            e = q.pop_front();
            chk("bcd_tens", bcd_tens, e.t);
            chk("bcd_ones", bcd_ones, e.o);
            chk("latency_edge", edge_n, e.e);
          end
        end
        if (pv && !valid) begin
          checks++;
          errors++;
          $display("FAIL valid_sticky actual=0 required=1 (edge %0d)", edge_n);
        end
        pv = valid; pt = bcd_tens; po = bcd_ones;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    // power-up conversion of 0 and initial display
    step(12);
    // 0 -> 63
    seconds = 6'd63;
    step(12);
    // 9 -> 10 -> 11
    seconds = 6'd9;  step(4);
    seconds = 6'd10; step(4);
    seconds = 6'd11; step(8);
    // 63 then 12 one cycle into CONVERT
    seconds = 6'd0;  step(10);
    seconds = 6'd63; step(2);
    seconds = 6'd12; step(20);
    // blanking while the mux keeps running
    blank = 1'b1; step(10);
    blank = 1'b0; step(10);
    // reset in the middle of converting 63
    seconds = 6'd0;  step(10);
    seconds = 6'd63; step(3);
    reset = 1'b1;    step(2);
    reset = 1'b0;    step(14);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      seconds = 6'($urandom_range(0, 63));
      blank   = ($urandom_range(0, 7) == 0);
      step($urandom_range(1, 10));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    blank = 1'b0;
    step(20);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
